gpio_reg_arb: RTL and testbench

- Two-master arbiter for the GPIO register-bus slave port (cs/wr/addr/wdata/be in, rdata/ack out).
- Shares the port between master 0 (RISC core bridge) and master 1 (autonomous sequencer, e.g. WS281x/pattern engine).
- Round-robin grant.
- Latches the winning command, drives it to the slave, and returns the slave's rdata/ack to the granted master only.
- Optional watchdog aborts transfers the slave never acknowledges.

---
 rtl/gpio_reg_arb.sv | 216 +++++++++++++++++++++
 tb/tb_gpio_reg_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_reg_arb.sv
// gpio_reg_arb: two-master round-robin arbiter in front of the GPIO register-bus
// slave port. Master 0 is the RISC core bridge and master 1 is the autonomous
// sequencer. The arbiter latches the winning command, drives it to the slave,
// and routes the slave's rdata/ack back to the granted master only.
//
// Optional build macro: GPIO_ARB_TIMEOUT_EN adds a watchdog that aborts a
// transfer after TO_CYC cycles in BUSY without a slave ack. On an abort the
// owner gets rdata 32'hDEAD_BEEF with an ack pulse, and arb_to_err pulses.
//
// Ports:
//   mclk, h_reset_n          clock, asynchronous active-low reset
//   m{0,1}_reg_cs/wr/addr/wdata/be   master command inputs (cs held until ack)
//   m{0,1}_reg_rdata/ack     per-master read data and one-cycle ack pulse
//   s_reg_cs/wr/addr/wdata/be        registered command to the slave
//   s_reg_rdata/ack          slave response (rdata valid with ack)
//   arb_gnt                  one-hot current owner, 00 when idle
//   arb_to_err               one-cycle pulse on watchdog abort
//
// state | meaning
// IDLE  | no transfer; arbitrate pending requests
// BUSY  | command on the slave port, waiting for s_reg_ack
// DONE  | one cycle with s_reg_cs low so the slave ack can drop

module gpio_reg_arb #(
  parameter int AW     = 4,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic            mclk,
  input  logic            h_reset_n,
  input  logic            m0_reg_cs,
  input  logic            m0_reg_wr,
  input  logic [AW-1:0]   m0_reg_addr,
  input  logic [DW-1:0]   m0_reg_wdata,
  input  logic [DW/8-1:0] m0_reg_be,
  output logic [DW-1:0]   m0_reg_rdata,
  output logic            m0_reg_ack,
  input  logic            m1_reg_cs,
  input  logic            m1_reg_wr,
  input  logic [AW-1:0]   m1_reg_addr,
  input  logic [DW-1:0]   m1_reg_wdata,
  input  logic [DW/8-1:0] m1_reg_be,
  output logic [DW-1:0]   m1_reg_rdata,
  output logic            m1_reg_ack,
  output logic            s_reg_cs,
  output logic            s_reg_wr,
  output logic [AW-1:0]   s_reg_addr,
  output logic [DW-1:0]   s_reg_wdata,
  output logic [DW/8-1:0] s_reg_be,
  input  logic [DW-1:0]   s_reg_rdata,
  input  logic            s_reg_ack,
  output logic [1:0]      arb_gnt,
  output logic            arb_to_err
);

  localparam int BW = DW / 8;

  if (TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_to_cyc
    $error("gpio_reg_arb: TO_CYC must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;   // 0 = master 0, 1 = master 1
  logic [1:0]      gnt_q, gnt_d;
  logic            s_cs_q, s_cs_d;
  logic            s_wr_q, s_wr_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;
  logic [BW-1:0]   s_be_q, s_be_d;
  logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DW-1:0]   m1_rdata_q, m1_rdata_d;
  logic            m0_ack_q, m0_ack_d;
  logic            m1_ack_q, m1_ack_d;

  logic            req0, req1, win1;

  // A master whose ack is currently high has just been served; its cs may
  // still be high for this cycle and must not start a second transfer.
  assign req0 = m0_reg_cs & ~m0_ack_q;
  assign req1 = m1_reg_cs & ~m1_ack_q;
  assign win1 = req1 & (~req0 | ~last_gnt_q);

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        to_err_q, to_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    s_cs_d     = s_cs_q;
    s_wr_d     = s_wr_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_be_d     = s_be_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
`ifdef GPIO_ARB_TIMEOUT_EN
    wdog_d     = wdog_q;
    to_err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = BUSY;
          s_cs_d     = 1'b1;
          last_gnt_d = win1;
          gnt_d      = win1 ? 2'b10 : 2'b01;
          s_wr_d     = win1 ? m1_reg_wr    : m0_reg_wr;
          s_addr_d   = win1 ? m1_reg_addr  : m0_reg_addr;
          s_wdata_d  = win1 ? m1_reg_wdata : m0_reg_wdata;
          s_be_d     = win1 ? m1_reg_be    : m0_reg_be;
`ifdef GPIO_ARB_TIMEOUT_EN
          wdog_d     = '0;
`endif
        end
      end
      BUSY: begin
        if (s_reg_ack) begin
          state_d = DONE;
          s_cs_d  = 1'b0;
          gnt_d   = 2'b00;
          if (gnt_q[1]) begin
            m1_rdata_d = s_reg_rdata;
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = s_reg_rdata;
            m0_ack_d   = 1'b1;
          end
`ifdef GPIO_ARB_TIMEOUT_EN
        end else if (wdog_q == TO_LAST) begin
          // Limit reached this cycle; an ack in the same cycle took the branch above.
          state_d  = DONE;
          s_cs_d   = 1'b0;
          gnt_d    = 2'b00;
          to_err_d = 1'b1;
          if (gnt_q[1]) begin
            m1_rdata_d = DW'(32'hDEAD_BEEF);
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = DW'(32'hDEAD_BEEF);
            m0_ack_d   = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + 16'd1;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 2'b00;
      s_cs_q     <= 1'b0;
      s_wr_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_be_q     <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      s_cs_q     <= s_cs_d;
      s_wr_q     <= s_wr_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_be_q     <= s_be_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
    end
  end

`ifdef GPIO_ARB_TIMEOUT_EN
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      wdog_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      to_err_q <= to_err_d;
    end
  end
  assign arb_to_err = to_err_q;
`else
  assign arb_to_err = 1'b0;
`endif

  assign s_reg_cs     = s_cs_q;
  assign s_reg_wr     = s_wr_q;
  assign s_reg_addr   = s_addr_q;
  assign s_reg_wdata  = s_wdata_q;
  assign s_reg_be     = s_be_q;
  assign m0_reg_rdata = m0_rdata_q;
  assign m1_reg_rdata = m1_rdata_q;
  assign m0_reg_ack   = m0_ack_q;
  assign m1_reg_ack   = m1_ack_q;
  assign arb_gnt      = gnt_q;

endmodule

// File: tb/tb_gpio_reg_arb.sv
// Directed self-checking bench for gpio_reg_arb. Inputs are driven and outputs
// sampled on the falling edge; a value driven at the falling edge of cycle k is
// the input seen by the rising edge that ends cycle k.
module tb_gpio_reg_arb;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          mclk = 1'b0;
  logic          h_reset_n;
  logic          m0_reg_cs, m0_reg_wr, m1_reg_cs, m1_reg_wr;
  logic [AW-1:0] m0_reg_addr, m1_reg_addr, s_reg_addr;
  logic [DW-1:0] m0_reg_wdata, m1_reg_wdata, s_reg_wdata;
  logic [3:0]    m0_reg_be, m1_reg_be, s_reg_be;
  logic [DW-1:0] m0_reg_rdata, m1_reg_rdata, s_reg_rdata;
  logic          m0_reg_ack, m1_reg_ack;
  logic          s_reg_cs, s_reg_wr, s_reg_ack;
  logic [1:0]    arb_gnt;
  logic          arb_to_err;

  int checks = 0;
  int failures = 0;

  gpio_reg_arb #(.AW(AW), .DW(DW), .TO_CYC(8)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n),
    .m0_reg_cs(m0_reg_cs), .m0_reg_wr(m0_reg_wr), .m0_reg_addr(m0_reg_addr),
    .m0_reg_wdata(m0_reg_wdata), .m0_reg_be(m0_reg_be),
    .m0_reg_rdata(m0_reg_rdata), .m0_reg_ack(m0_reg_ack),
    .m1_reg_cs(m1_reg_cs), .m1_reg_wr(m1_reg_wr), .m1_reg_addr(m1_reg_addr),
    .m1_reg_wdata(m1_reg_wdata), .m1_reg_be(m1_reg_be),
    .m1_reg_rdata(m1_reg_rdata), .m1_reg_ack(m1_reg_ack),
    .s_reg_cs(s_reg_cs), .s_reg_wr(s_reg_wr), .s_reg_addr(s_reg_addr),
    .s_reg_wdata(s_reg_wdata), .s_reg_be(s_reg_be),
    .s_reg_rdata(s_reg_rdata), .s_reg_ack(s_reg_ack),
    .arb_gnt(arb_gnt), .arb_to_err(arb_to_err)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge mclk);
  endtask

  initial begin
    h_reset_n = 1'b0;
    m0_reg_cs = 0; m0_reg_wr = 0; m0_reg_addr = '0; m0_reg_wdata = '0; m0_reg_be = '0;
    m1_reg_cs = 0; m1_reg_wr = 0; m1_reg_addr = '0; m1_reg_wdata = '0; m1_reg_be = '0;
    s_reg_ack = 0; s_reg_rdata = '0;
    step(); step();
    chk("rst_s_cs", 32'(s_reg_cs), 0);
    chk("rst_gnt", 32'(arb_gnt), 0);
    chk("rst_m0_ack", 32'(m0_reg_ack), 0);
    chk("rst_m0_rdata", m0_reg_rdata, 0);
    chk("rst_to_err", 32'(arb_to_err), 0);
    h_reset_n = 1'b1;
    step();

    // M0 write, slave latency 1
    m0_reg_cs = 1; m0_reg_wr = 1; m0_reg_addr = 4'h3; m0_reg_wdata = 32'hA5A5_0F0F; m0_reg_be = 4'hF;
    step();                                          // cycle 1
    chk("w_s_cs_c1", 32'(s_reg_cs), 1);
    chk("w_s_wr", 32'(s_reg_wr), 1);
    chk("w_s_addr", 32'(s_reg_addr), 32'h3);
    chk("w_s_wdata", s_reg_wdata, 32'hA5A5_0F0F);
    chk("w_s_be", 32'(s_reg_be), 32'hF);
    chk("w_gnt", 32'(arb_gnt), 32'b01);
    chk("w_m0_ack_c1", 32'(m0_reg_ack), 0);
    step();                                          // cycle 2
    chk("w_s_cs_c2", 32'(s_reg_cs), 1);
    s_reg_ack = 1; s_reg_rdata = 32'h0BAD_F00D;
    step();                                          // cycle 3
    s_reg_ack = 0; s_reg_rdata = '0;
    chk("w_m0_ack_c3", 32'(m0_reg_ack), 1);
    chk("w_m1_ack_c3", 32'(m1_reg_ack), 0);
    chk("w_s_cs_c3", 32'(s_reg_cs), 0);
    chk("w_gnt_done", 32'(arb_gnt), 0);
    chk("w_m0_rdata", m0_reg_rdata, 32'h0BAD_F00D);
    m0_reg_cs = 0;
    step();                                          // cycle 4
    chk("w_m0_ack_c4", 32'(m0_reg_ack), 0);

    // M1 read
    m1_reg_cs = 1; m1_reg_wr = 0; m1_reg_addr = 4'h2; m1_reg_be = 4'hF;
    step();
    chk("r_gnt", 32'(arb_gnt), 32'b10);
    chk("r_s_wr", 32'(s_reg_wr), 0);
    chk("r_s_addr", 32'(s_reg_addr), 32'h2);
    step();
    s_reg_ack = 1; s_reg_rdata = 32'h1234_5678;
    step();
    s_reg_ack = 0;
    chk("r_m1_ack", 32'(m1_reg_ack), 1);
    chk("r_m1_rdata", m1_reg_rdata, 32'h1234_5678);
    chk("r_m0_ack", 32'(m0_reg_ack), 0);
    chk("r_m0_rdata_hold", m0_reg_rdata, 32'h0BAD_F00D);
    m1_reg_cs = 0;
    step();

    // Stray slave ack while idle is ignored
    s_reg_ack = 1; s_reg_rdata = 32'hFFFF_FFFF;
    step();
    s_reg_ack = 0;
    chk("ign_m0_ack", 32'(m0_reg_ack), 0);
    chk("ign_m1_ack", 32'(m1_reg_ack), 0);
    chk("ign_m1_rdata", m1_reg_rdata, 32'h1234_5678);
    chk("ign_s_cs", 32'(s_reg_cs), 0);

    // Both masters requesting continuously: last grant was M1, so M0 goes first
    m0_reg_cs = 1; m0_reg_wr = 1; m0_reg_addr = 4'h5; m0_reg_wdata = 32'h0;
    m1_reg_cs = 1; m1_reg_wr = 0; m1_reg_addr = 4'hA;
    for (int i = 0; i < 12; i++) begin
      logic own;
      own = i[0];
      step();                                        // BUSY, first cycle
      chk("rr_gnt", 32'(arb_gnt), own ? 32'b10 : 32'b01);
      chk("rr_s_cs", 32'(s_reg_cs), 1);
      chk("rr_s_addr", 32'(s_reg_addr), own ? 32'hA : 32'h5);
      step();                                        // BUSY, slave acks
      s_reg_ack = 1; s_reg_rdata = 32'h100 + 32'(i);
      step();                                        // DONE
      s_reg_ack = 0;
      chk("rr_m0_ack", 32'(m0_reg_ack), own ? 0 : 1);
      chk("rr_m1_ack", 32'(m1_reg_ack), own ? 1 : 0);
      chk("rr_rdata", own ? m1_reg_rdata : m0_reg_rdata, 32'h100 + 32'(i));
      chk("rr_s_cs_done", 32'(s_reg_cs), 0);
      chk("rr_gnt_done", 32'(arb_gnt), 0);
      step();                                        // IDLE
      chk("rr_s_cs_idle", 32'(s_reg_cs), 0);
    end
    m0_reg_cs = 0; m1_reg_cs = 0;
    step();

    // M0 drops cs and changes its command while BUSY
    m0_reg_cs = 1; m0_reg_wr = 1; m0_reg_addr = 4'h7; m0_reg_wdata = 32'h1111_2222; m0_reg_be = 4'h3;
    step();
    chk("drop_s_addr_b1", 32'(s_reg_addr), 32'h7);
    m0_reg_cs = 0; m0_reg_addr = 4'h1; m0_reg_wdata = '0; m0_reg_be = '0;
    step();
    chk("drop_s_addr_b2", 32'(s_reg_addr), 32'h7);
    chk("drop_s_wdata", s_reg_wdata, 32'h1111_2222);
    chk("drop_s_be", 32'(s_reg_be), 32'h3);
    chk("drop_s_cs", 32'(s_reg_cs), 1);
    step();
    s_reg_ack = 1; s_reg_rdata = 32'h77;
    chk("drop_s_addr_b3", 32'(s_reg_addr), 32'h7);
    step();
    s_reg_ack = 0;
    chk("drop_m0_ack", 32'(m0_reg_ack), 1);
    step();
    chk("drop_m0_ack_once", 32'(m0_reg_ack), 0);
    chk("drop_s_cs_after", 32'(s_reg_cs), 0);
    step();
    chk("drop_gnt_idle", 32'(arb_gnt), 0);

    // Reset in BUSY after an M0 grant; after release M0 must still win the tie
    m0_reg_cs = 1; m0_reg_wr = 0; m0_reg_addr = 4'h4;
    step();
    chk("rb_gnt_before", 32'(arb_gnt), 32'b01);
    m1_reg_cs = 1; m1_reg_wr = 0; m1_reg_addr = 4'hA;
    h_reset_n = 0;
    #1;
    chk("rb_s_cs", 32'(s_reg_cs), 0);
    chk("rb_gnt", 32'(arb_gnt), 0);
    chk("rb_s_addr", 32'(s_reg_addr), 0);
    chk("rb_m0_rdata", m0_reg_rdata, 0);
    chk("rb_m1_rdata", m1_reg_rdata, 0);
    step();
    h_reset_n = 1;
    step();
    chk("rb_first_gnt", 32'(arb_gnt), 32'b01);
    chk("rb_first_addr", 32'(s_reg_addr), 32'h4);
    s_reg_ack = 1; s_reg_rdata = 32'h4444;
    step();
    s_reg_ack = 0;
    chk("rb_m0_ack", 32'(m0_reg_ack), 1);
    m0_reg_cs = 0;
    step();
    step();
    chk("rb_second_gnt", 32'(arb_gnt), 32'b10);
    s_reg_ack = 1; s_reg_rdata = 32'h5555;
    step();
    s_reg_ack = 0;
    chk("rb_m1_ack", 32'(m1_reg_ack), 1);
    m1_reg_cs = 0;
    step();

    // Slave never acks: abort after 8 BUSY cycles when the watchdog is built in
    m0_reg_cs = 1; m0_reg_wr = 0; m0_reg_addr = 4'h9;
    repeat (8) step();                               // cycle 8, still BUSY
    chk("to_s_cs_c8", 32'(s_reg_cs), 1);
    chk("to_err_c8", 32'(arb_to_err), 0);
    step();                                          // cycle 9
`ifdef GPIO_ARB_TIMEOUT_EN
    chk("to_s_cs_c9", 32'(s_reg_cs), 0);
    chk("to_m0_ack", 32'(m0_reg_ack), 1);
    chk("to_m0_rdata", m0_reg_rdata, 32'hDEAD_BEEF);
    chk("to_err_pulse", 32'(arb_to_err), 1);
    m0_reg_cs = 0;
    step();
    chk("to_err_clear", 32'(arb_to_err), 0);
    chk("to_m0_ack_clear", 32'(m0_reg_ack), 0);
`else
    chk("nto_s_cs_c9", 32'(s_reg_cs), 1);
    chk("nto_err", 32'(arb_to_err), 0);
    s_reg_ack = 1; s_reg_rdata = 32'h55AA;
    step();
    s_reg_ack = 0;
    chk("nto_m0_ack", 32'(m0_reg_ack), 1);
    chk("nto_m0_rdata", m0_reg_rdata, 32'h55AA);
    m0_reg_cs = 0;
    step();
`endif

    // Ack lands in the cycle the watchdog limit is reached: normal completion
    m0_reg_cs = 1;
    repeat (8) step();                               // cycle 8
    s_reg_ack = 1; s_reg_rdata = 32'h600D_CAFE;
    step();
    s_reg_ack = 0;
    chk("edge_m0_ack", 32'(m0_reg_ack), 1);
    chk("edge_m0_rdata", m0_reg_rdata, 32'h600D_CAFE);
    chk("edge_to_err", 32'(arb_to_err), 0);
    chk("edge_s_cs", 32'(s_reg_cs), 0);
    m0_reg_cs = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
